// File: rtl/h264_dcquant_chroma_if.sv
// Chroma DC quantiser stream bundle: coefficient input handshake and level output handshake.
interface h264_dcquant_chroma_if #(
   parameter int IW = 16,
   parameter int OW = 12
);
   logic                 ENABLE;
   logic signed [IW-1:0] YYIN;
   logic [5:0]           QP;
   logic                 READYI;
   logic                 VALID;
   logic signed [OW-1:0] ZOUT;
   logic                 LAST;
   logic [2:0]           NZCOUNT;
   logic                 READYO;

   // master: upstream producer plus downstream consumer; slave: the quantiser
   modport master (
      output ENABLE, YYIN, QP, READYO,
      input  READYI, VALID, ZOUT, LAST, NZCOUNT
   );
   modport slave (
      input  ENABLE, YYIN, QP, READYO,
      output READYI, VALID, ZOUT, LAST, NZCOUNT
   );
endinterface

// File: rtl/h264_dcquant_chroma.sv
// H.264 2x2 chroma DC quantiser: 3-stage pipeline, QP tagged per block,
// saturating signed levels with per-block LAST marker and nonzero count.
module h264_dcquant_chroma #(
   parameter int IW = 16,
   parameter int OW = 12
) (
   input logic                  CLK,
   input logic                  RESET,
   h264_dcquant_chroma_if.slave bus
);
   localparam int unsigned MFW  = 14;
   localparam int unsigned PW   = IW + MFW;
   localparam int unsigned SUMW = PW + 1;
   localparam int unsigned SHW  = 5;
   localparam int unsigned RW   = 23;
   localparam int unsigned QMAX = (2 ** (OW - 1)) - 1;

   logic            adv_c, acc_c, hs_c;
   logic [1:0]      ixi_q, ixo_q;
   logic [3:0]      qpdiv6_q, qpdiv_c, cur_div_c;
   logic [2:0]      qpmod6_q, qpmod_c, cur_mod_c;
   logic [5:0]      qp_cl_c;
   logic [IW-1:0]   yy_u_c, mag_c;
   logic [MFW-1:0]  mf_c;
   logic [RW-1:0]   rnd_c;
   logic [SUMW-1:0] sum_c, q_c;
   logic [OW-1:0]   q_sat_c, z_c;
   logic [2:0]      nz_q, nz_now_c;

   logic            s1_v, s1_sign;
   logic [IW-1:0]   s1_mag;
   logic [MFW-1:0]  s1_mf;
   logic [SHW-1:0]  s1_sh;
   logic            s2_v, s2_sign;
   logic [PW-1:0]   s2_prod;
   logic [RW-1:0]   s2_rnd;
   logic [SHW-1:0]  s2_sh;
   logic            s3_v;
   logic [OW-1:0]   s3_z;

   assign adv_c      = bus.READYO | ~s3_v;
   assign acc_c      = bus.ENABLE & adv_c;
   assign hs_c       = s3_v & bus.READYO;
   assign bus.READYI = adv_c;

   // QP split; the first coefficient of a block uses the live QP, the rest the latched tag
   always_comb begin
      qp_cl_c = (bus.QP > 6'd51) ? 6'd51 : bus.QP;
      qpdiv_c = 4'd0;
      for (int unsigned k = 1; k <= 8; k++) begin
         if (qp_cl_c >= 6'(6 * k)) qpdiv_c = 4'(k);
      end
      qpmod_c   = 3'(qp_cl_c - 6'(6 * qpdiv_c));
      cur_div_c = (ixi_q == 2'd0) ? qpdiv_c : qpdiv6_q;
      cur_mod_c = (ixi_q == 2'd0) ? qpmod_c : qpmod6_q;
   end

   // S1 operands: sign/magnitude and DC multiplier
   always_comb begin
      yy_u_c = bus.YYIN;
      mag_c  = yy_u_c[IW-1] ? (~yy_u_c + IW'(1)) : yy_u_c;
      mf_c   = 14'd13107;
      case (cur_mod_c)
         3'd0:    mf_c = 14'd13107;
         3'd1:    mf_c = 14'd11916;
         3'd2:    mf_c = 14'd10082;
         3'd3:    mf_c = 14'd9362;
         3'd4:    mf_c = 14'd8192;
         3'd5:    mf_c = 14'd7282;
         default: mf_c = 14'd13107;
      endcase
   end

   // intra rounding offset floor(2^sh/3)
   always_comb begin
      rnd_c = 23'd21845;
      case (s1_sh)
         5'd16:   rnd_c = 23'd21845;
         5'd17:   rnd_c = 23'd43690;
         5'd18:   rnd_c = 23'd87381;
         5'd19:   rnd_c = 23'd174762;
         5'd20:   rnd_c = 23'd349525;
         5'd21:   rnd_c = 23'd699050;
         5'd22:   rnd_c = 23'd1398101;
         5'd23:   rnd_c = 23'd2796202;
         5'd24:   rnd_c = 23'd5592405;
         default: rnd_c = 23'd21845;
      endcase
   end

   // S3 rounding shift, saturation and sign restore
   always_comb begin
      sum_c   = SUMW'(s2_prod) + SUMW'(s2_rnd);
      q_c     = sum_c >> s2_sh;
      q_sat_c = (q_c > SUMW'(QMAX)) ? OW'(QMAX) : q_c[OW-1:0];
      z_c     = s2_sign ? (~q_sat_c + OW'(1)) : q_sat_c;
   end

   // input index and per-block QP tag
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ixi_q    <= 2'd0;
         qpdiv6_q <= 4'd0;
         qpmod6_q <= 3'd0;
      end else if (acc_c) begin
         ixi_q <= ixi_q + 2'd1;
         if (ixi_q == 2'd0) begin
            qpdiv6_q <= qpdiv_c;
            qpmod6_q <= qpmod_c;
         end
      end
   end

   // pipeline stages advance together
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         s1_v    <= 1'b0;
         s1_sign <= 1'b0;
         s1_mag  <= '0;
         s1_mf   <= '0;
         s1_sh   <= '0;
         s2_v    <= 1'b0;
         s2_sign <= 1'b0;
         s2_prod <= '0;
         s2_rnd  <= '0;
         s2_sh   <= '0;
         s3_v    <= 1'b0;
         s3_z    <= '0;
      end else if (adv_c) begin
         s1_v    <= acc_c;
         s1_sign <= yy_u_c[IW-1];
         s1_mag  <= mag_c;
         s1_mf   <= mf_c;
         s1_sh   <= SHW'(cur_div_c) + 5'd16;
         s2_v    <= s1_v;
         s2_sign <= s1_sign;
         s2_prod <= PW'(s1_mag) * PW'(s1_mf);
         s2_rnd  <= rnd_c;
         s2_sh   <= s1_sh;
         s3_v    <= s2_v;
         s3_z    <= z_c;
      end
   end

   // output index and nonzero tally, cleared after the block's last level leaves
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ixo_q <= 2'd0;
         nz_q  <= 3'd0;
      end else if (hs_c) begin
         ixo_q <= ixo_q + 2'd1;
         nz_q  <= (ixo_q == 2'd3) ? 3'd0 : nz_now_c;
      end
   end

   assign nz_now_c    = nz_q + 3'(s3_z != '0);
   assign bus.VALID   = s3_v;
   assign bus.ZOUT    = s3_z;
   assign bus.LAST    = s3_v & (ixo_q == 2'd3);
   assign bus.NZCOUNT = bus.LAST ? nz_now_c : 3'd0;
endmodule

// File: tb/tb_h264_dcquant_chroma.sv
// Randomised scoreboard bench for the chroma DC quantiser against an arithmetic reference.
module tb_h264_dcquant_chroma;
   localparam int IW = 16;
   localparam int OW = 12;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;
   always #5 CLK = ~CLK;

   h264_dcquant_chroma_if #(.IW(IW), .OW(OW)) bus ();
   h264_dcquant_chroma #(.IW(IW), .OW(OW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

   typedef struct {
      int z;
      int last;
      int nz;
      int acc;
      bit lat;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   m_idx = 0;
   int   m_qp  = 0;
   int   m_nz  = 0;
   int   stall_req = 0;
   bit   ro_rand   = 1'b0;
   bit   lat_chk   = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // quantised level straight from the arithmetic definition
   function automatic int ref_level(input int w, input int qp);
      int     mf_t[6] = '{13107, 11916, 10082, 9362, 8192, 7282};
      int     qc;
      int     sh;
      longint mag;
      longint q;
      qc  = (qp > 51) ? 51 : qp;
      sh  = qc / 6 + 16;
      mag = (w < 0) ? -longint'(w) : longint'(w);
      q   = (mag * mf_t[qc % 6] + ((longint'(1) << sh) / 3)) >> sh;
      if (q > 2047) q = 2047;
      return (w < 0) ? -int'(q) : int'(q);
   endfunction

   task automatic model_accept(input int w, input int qp);
      exp_t e;
      int   lvl;
      if (m_idx == 0) m_qp = qp;
      lvl = ref_level(w, m_qp);
      if (lvl != 0) m_nz++;
      e.z    = lvl;
      e.last = (m_idx == 3) ? 1 : 0;
      e.nz   = (m_idx == 3) ? m_nz : 0;
      e.acc  = cyc;
      e.lat  = lat_chk;
      sb.push_back(e);
      if (m_idx == 3) m_nz = 0;
      m_idx = (m_idx + 1) % 4;
   endtask

   task automatic send(input int w, input int qp);
      bit got = 1'b0;
      int guard = 0;
      while (!got && guard < 200) begin
         @(negedge CLK);
         bus.ENABLE = 1'b1;
         bus.YYIN   = 16'(w);
         bus.QP     = 6'(qp);
         #1;
         if (bus.READYI) begin
            model_accept(w, qp);
            got = 1'b1;
         end
         guard++;
      end
      if (!got) check("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         bus.ENABLE = 1'b0;
         bus.YYIN   = 16'($urandom);
         bus.QP     = 6'($urandom);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge CLK);
         bus.ENABLE = 1'b0;
         t++;
      end
      check("drain_outstanding", sb.size(), 0);
      sb.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},   int'(bus.VALID), 0);
      check({tag, "_last"},    int'(bus.LAST), 0);
      check({tag, "_zout"},    int'($signed(bus.ZOUT)), 0);
      check({tag, "_nzcount"}, int'(bus.NZCOUNT), 0);
      check({tag, "_readyi"},  int'(bus.READYI), 1);
   endtask

   // downstream ready: forced stall windows, otherwise always-ready or random
   initial begin
      int stall_ack = 0;
      int cnt = 0;
      bus.READYO = 1'b1;
      forever begin
         @(negedge CLK);
         if (stall_req != stall_ack) begin
            stall_ack = stall_req;
            cnt = 5;
         end
         if (cnt > 0) begin
            bus.READYO = 1'b0;
            cnt--;
         end else if (ro_rand) begin
            bus.READYO = ($urandom_range(0, 9) < 7);
         end else begin
            bus.READYO = 1'b1;
         end
      end
   end

   // monitor: pop and compare on each handshake, check hold behaviour during stalls
   initial begin
      bit   prev_stall = 1'b0;
      int   held_z = 0;
      int   held_last = 0;
      int   held_nz = 0;
      exp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (!RESET) begin
            prev_stall = 1'b0;
         end else begin
            if (!bus.VALID) check("idle_last", int'(bus.LAST), 0);
            if (bus.VALID && !bus.READYO) begin
               check("stall_readyi", int'(bus.READYI), 0);
               if (prev_stall) begin
                  check("stall_zout_held", int'($signed(bus.ZOUT)), held_z);
                  check("stall_last_held", int'(bus.LAST), held_last);
                  check("stall_nz_held",   int'(bus.NZCOUNT), held_nz);
               end
               prev_stall = 1'b1;
               held_z     = int'($signed(bus.ZOUT));
               held_last  = int'(bus.LAST);
               held_nz    = int'(bus.NZCOUNT);
            end else begin
               prev_stall = 1'b0;
            end
            if (bus.VALID && bus.READYO) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_output: got level %0d expected no output (cycle %0d)",
                           int'($signed(bus.ZOUT)), cyc);
               end else begin
                  e = sb.pop_front();
                  check("zout",    int'($signed(bus.ZOUT)), e.z);
                  check("last",    int'(bus.LAST), e.last);
                  check("nzcount", int'(bus.NZCOUNT), e.nz);
                  if (e.lat) check("latency", cyc - e.acc, 3);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached with %0d outstanding", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic signed [15:0] r16;
      int xw[5] = '{32767, -32768, 0, -1, 1};
      bus.ENABLE = 1'b0;
      bus.YYIN   = '0;
      bus.QP     = '0;

      @(negedge CLK);
      #1;
      check_reset_outputs("reset");
      @(negedge CLK);
      RESET = 1'b1;
      idle(2);

      // directed vectors, continuous input and ready, fixed latency expected
      lat_chk = 1'b1;
      send(1000, 28);  send(-1000, 28); send(0, 28);      send(1, 28);
      send(100, 0);    send(32767, 0);  send(-32768, 0);  send(-1, 0);
      send(32767, 51); send(-32768, 51); send(5000, 51);  send(-5000, 51);
      drain();

      // QP change inside block A must not affect it; block B follows without a bubble
      send(3000, 0);   send(-700, 0);   send(450, 28);    send(-20000, 28);
      send(3000, 28);  send(-700, 28);  send(450, 28);    send(-20000, 28);
      drain();
      lat_chk = 1'b0;

      // stall after the first level while input keeps pushing
      fork
         begin
            for (int i = 0; i < 12; i++) send($urandom_range(0, 8000) - 4000, 20);
         end
         begin
            int t = 0;
            while (!bus.VALID && t < 50) begin
               @(negedge CLK);
               #1;
               t++;
            end
            check("stall_first_valid_seen", int'(bus.VALID), 1);
            stall_req = stall_req + 1;
         end
      join
      drain();

      // reset in the middle of a block, then a fresh block
      send(2000, 28);
      send(-2000, 28);
      @(negedge CLK);
      RESET      = 1'b0;
      bus.ENABLE = 1'b0;
      #1;
      check_reset_outputs("midreset");
      sb.delete();
      m_idx = 0;
      m_nz  = 0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      send(2000, 28); send(0, 28); send(-3000, 28); send(7, 28);
      drain();

      // randomised traffic with random back-pressure and gaps
      ro_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: begin r16 = 16'($urandom); w = int'(r16); end
            1: w = int'($urandom_range(0, 400)) - 200;
            2: w = xw[$urandom_range(0, 4)];
            default: w = int'($urandom_range(0, 20000)) - 10000;
         endcase
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         send(w, $urandom_range(0, 63));
      end
      drain();
      ro_rand = 1'b0;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
